// File: rtl/stream_packer.sv
// Packs RATIO consecutive upstream words, LSB-first, into one wide word on a
// valid/ready output register; flush emits a zero-padded partial word with its count.
module stream_packer #(
  parameter int DATA_WIDTH  = 6,
  parameter int RATIO       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_ready,
  input  logic [DATA_WIDTH-1:0]         up_data,
  output logic                          up_pop,
  input  logic                          flush,
  output logic                          dn_valid,
  output logic [DATA_WIDTH*RATIO-1:0]   dn_data,
  output logic [COUNT_WIDTH-1:0]        dn_count,
  input  logic                          dn_ready
);

  localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int ACC_W = DATA_WIDTH * (RATIO - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]              r_cnt;
  logic [ACC_W-1:0]              r_acc;
  logic                          r_dn_valid;
  logic [DATA_WIDTH*RATIO-1:0]   r_dn_data;
  logic [COUNT_WIDTH-1:0]        r_dn_count;
  logic                          r_flush_pending;
  logic                          w_out_free;
  logic                          w_pop;

  assign w_out_free = !r_dn_valid || dn_ready;
  // Only the word completing a pack needs the output register free.
  assign w_pop = up_ready && !r_flush_pending && !rst && ((r_cnt != LAST) || w_out_free);

  assign up_pop   = w_pop;
  assign dn_valid = r_dn_valid;
  assign dn_data  = r_dn_data;
  assign dn_count = r_dn_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_acc           <= '0;
      r_dn_valid      <= 1'b0;
      r_dn_data       <= '0;
      r_dn_count      <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (r_dn_valid && dn_ready) begin
        r_dn_valid <= 1'b0;
      end
      if (flush && !r_flush_pending) begin
        r_flush_pending <= 1'b1;
      end
      // Pops are blocked while a flush is pending, so the two branches never compete.
      if (r_flush_pending && w_out_free) begin
        if (r_cnt != '0) begin
          r_dn_data  <= {{DATA_WIDTH{1'b0}}, r_acc};
          r_dn_count <= COUNT_WIDTH'(r_cnt);
          r_dn_valid <= 1'b1;
        end
        r_cnt           <= '0;
        r_acc           <= '0;
        r_flush_pending <= 1'b0;
      end else if (w_pop) begin
        if (r_cnt == LAST) begin
          r_dn_data  <= {up_data, r_acc};
          r_dn_count <= COUNT_WIDTH'(RATIO);
          r_dn_valid <= 1'b1;
          r_cnt      <= '0;
          r_acc      <= '0;
        end else begin
          for (int unsigned k = 0; k < RATIO - 1; k++) begin
            if (r_cnt == CNT_W'(k)) begin
              r_acc[k*DATA_WIDTH +: DATA_WIDTH] <= up_data;
            end
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
